// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule constants, tables, state enum and helpers
//
// Holds the PC-1 / PC-2 selection tables, the per-round shift table and the
// widths shared by the key-schedule RTL. Table entries use DES bit numbering
// (bit 1 = MSB of the vector).
package des_pkg;

  localparam int KEY_WIDTH    = 64;
  localparam int SUBKEY_WIDTH = 48;
  localparam int HALF_WIDTH   = 28;
  localparam int ROUNDS       = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 64-bit key (DES bit 1 = key[63]) -> 56-bit {C,D}; parity bits are dropped.
  function automatic logic [55:0] pc1_select(input logic [KEY_WIDTH-1:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = key[KEY_WIDTH - PC1[i]];
    end
    return r;
  endfunction

  function automatic logic [1:0] shift_of(input logic [3:0] idx);
    return SHIFT[idx];
  endfunction

  // Shift amounts are only ever 1 or 2.
  function automatic logic [HALF_WIDTH-1:0] rotl28(input logic [HALF_WIDTH-1:0] x,
                                                   input logic [1:0] amt);
    return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_WIDTH-1:0] rotr28(input logic [HALF_WIDTH-1:0] x,
                                                   input logic [1:0] amt);
    return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - key load / subkey handshake bundle
//
// master: key source and subkey consumer (drives key_in, key_valid, decrypt,
//         round_adv).
// slave : the key schedule (drives key_ready, subkey, subkey_valid,
//         round_idx, done, parity_err).
interface des_key_schedule_if;
  import des_pkg::*;

  logic [KEY_WIDTH-1:0]    key_in;
  logic                    key_valid;
  logic                    key_ready;
  logic                    decrypt;
  logic [SUBKEY_WIDTH-1:0] subkey;
  logic                    subkey_valid;
  logic [3:0]              round_idx;
  logic                    round_adv;
  logic                    done;
  logic                    parity_err;

  modport master (
    output key_in, key_valid, decrypt, round_adv,
    input  key_ready, subkey, subkey_valid, round_idx, done, parity_err
  );

  modport slave (
    input  key_in, key_valid, decrypt, round_adv,
    output key_ready, subkey, subkey_valid, round_idx, done, parity_err
  );

endinterface

// File: rtl/des_key_pc2.sv
// rtl/des_key_pc2.sv - combinational DES PC-2 selection (56 -> 48)
//
// Ports:
//   cd_in      : {C,D}, DES bit 1 = cd_in[55]
//   subkey_out : round key, DES bit 1 = subkey_out[47]
module des_key_pc2
  import des_pkg::*;
(
  input  logic [55:0]             cd_in,
  output logic [SUBKEY_WIDTH-1:0] subkey_out
);

  always_comb begin
    subkey_out = '0;
    for (int i = 0; i < SUBKEY_WIDTH; i++) begin
      subkey_out[SUBKEY_WIDTH-1-i] = cd_in[56 - PC2[i]];
    end
  end

  // DES bits 9,18,22,25,35,38,43,54 of {C,D} never reach a subkey.
  logic unused_dropped;
  assign unused_dropped = ^{cd_in[47], cd_in[38], cd_in[34], cd_in[31],
                            cd_in[21], cd_in[18], cd_in[13], cd_in[2]};

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES round-key generator
//
// Accepts a 64-bit key plus direction over key_valid/key_ready and steps the
// 16 key-schedule rounds one per round_adv, presenting PC-2(C,D) as subkey
// (K1..K16 for encrypt, K16..K1 for decrypt). done pulses the cycle after
// the last subkey is consumed.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   kif : des_key_schedule_if.slave (key_in, key_valid, key_ready, decrypt,
//         subkey, subkey_valid, round_idx, round_adv, done, parity_err)
//
// Build option: DES_KEY_SCHED_PARITY_EN enables odd-parity checking of each
// key byte at load; otherwise parity_err is tied 0.
module des_key_schedule
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  des_key_schedule_if.slave  kif
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e                  state_q, state_d;
  logic [HALF_WIDTH-1:0]   c_q, c_d;
  logic [HALF_WIDTH-1:0]   d_q, d_d;
  logic [3:0]              round_q, round_d;
  logic                    mode_q, mode_d;
  logic                    key_ready_q, key_ready_d;
  logic                    subkey_valid_q, subkey_valid_d;
  logic                    done_q, done_d;
  logic [55:0]             pc1_key;
  logic [1:0]              adv_shift;
  logic [SUBKEY_WIDTH-1:0] subkey_w;

  assign pc1_key = pc1_select(kif.key_in);

  // Encrypt moves C,D forward to the next round's rotation; decrypt undoes
  // the rotation that produced the current round (C16 = C0, so it starts
  // unrotated).
  assign adv_shift = mode_q ? shift_of(LAST_ROUND - round_q)
                            : shift_of(round_q + 4'd1);

`ifdef DES_KEY_SCHED_PARITY_EN
  logic parity_err_q, parity_err_d;
  logic parity_bad;

  always_comb begin
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      parity_bad = parity_bad | ~(^kif.key_in[8*b +: 8]);
    end
  end

  assign kif.parity_err = parity_err_q;
`else
  // Parity bits are not used by PC-1 when the check is not built.
  logic unused_parity_bits;
  assign unused_parity_bits = ^{kif.key_in[56], kif.key_in[48], kif.key_in[40],
                                kif.key_in[32], kif.key_in[24], kif.key_in[16],
                                kif.key_in[8],  kif.key_in[0]};

  assign kif.parity_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    c_d            = c_q;
    d_d            = d_q;
    round_d        = round_q;
    mode_d         = mode_q;
    key_ready_d    = key_ready_q;
    subkey_valid_d = subkey_valid_q;
    done_d         = 1'b0;
`ifdef DES_KEY_SCHED_PARITY_EN
    parity_err_d   = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (kif.key_valid) begin
          state_d        = RUN;
          key_ready_d    = 1'b0;
          subkey_valid_d = 1'b1;
          mode_d         = kif.decrypt;
          round_d        = 4'd0;
          if (kif.decrypt) begin
            c_d = pc1_key[55:28];
            d_d = pc1_key[27:0];
          end else begin
            c_d = rotl28(pc1_key[55:28], SHIFT[0]);
            d_d = rotl28(pc1_key[27:0], SHIFT[0]);
          end
`ifdef DES_KEY_SCHED_PARITY_EN
          parity_err_d = parity_bad;
`endif
        end
      end

      RUN: begin
        if (kif.round_adv) begin
          if (round_q == LAST_ROUND) begin
            state_d        = IDLE;
            key_ready_d    = 1'b1;
            subkey_valid_d = 1'b0;
            done_d         = 1'b1;
            round_d        = 4'd0;
          end else begin
            if (mode_q) begin
              c_d = rotr28(c_q, adv_shift);
              d_d = rotr28(d_q, adv_shift);
            end else begin
              c_d = rotl28(c_q, adv_shift);
              d_d = rotl28(d_q, adv_shift);
            end
            round_d = round_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      c_q            <= '0;
      d_q            <= '0;
      round_q        <= 4'd0;
      mode_q         <= 1'b0;
      key_ready_q    <= 1'b1;
      subkey_valid_q <= 1'b0;
      done_q         <= 1'b0;
`ifdef DES_KEY_SCHED_PARITY_EN
      parity_err_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      c_q            <= c_d;
      d_q            <= d_d;
      round_q        <= round_d;
      mode_q         <= mode_d;
      key_ready_q    <= key_ready_d;
      subkey_valid_q <= subkey_valid_d;
      done_q         <= done_d;
`ifdef DES_KEY_SCHED_PARITY_EN
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  des_key_pc2 u_pc2 (
    .cd_in      ({c_q, d_q}),
    .subkey_out (subkey_w)
  );

  assign kif.subkey       = subkey_w;
  assign kif.subkey_valid = subkey_valid_q;
  assign kif.key_ready    = key_ready_q;
  assign kif.round_idx    = round_q;
  assign kif.done         = done_q;

endmodule
